// File: rtl/n2r_ctrl.sv
// Sequencer for the normal-to-ready reshaping buffer: fills G-row groups, drains S slices per group.
// Optional stall counter output enabled by defining N2R_STALL_CNT_EN.
module n2r_ctrl #(
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 8,
  parameter int ROW        = 64,
  parameter int COL        = 256,
  localparam int G         = BLOCK_SIZE * NUM_CORES,
  localparam int S         = COL / BLOCK_SIZE,
  localparam int NG        = ROW / G,
  localparam int RW        = $clog2(G),
  localparam int SW        = $clog2(S),
  localparam int GW        = $clog2(NG) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_wr_en,
  output logic [RW-1:0] buf_wr_row,
  output logic [SW-1:0] buf_rd_slice,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [GW-1:0] group_idx,
  output logic          busy,
  output logic          done
`ifdef N2R_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  if ((ROW % G) != 0) begin : g_bad_row
    $error("n2r_ctrl: ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
  end
  if ((COL % BLOCK_SIZE) != 0) begin : g_bad_col
    $error("n2r_ctrl: COL must be a multiple of BLOCK_SIZE");
  end

  localparam logic [RW-1:0] ROW_LAST   = RW'(G - 1);
  localparam logic [SW-1:0] SLICE_LAST = SW'(S - 1);
  localparam logic [GW-1:0] GROUP_LAST = GW'(NG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_cnt, row_cnt_nxt;
  logic [SW-1:0] slice_cnt, slice_cnt_nxt;
  logic [GW-1:0] group_cnt, group_cnt_nxt;

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      slice_cnt <= '0;
      group_cnt <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_cnt_nxt;
      slice_cnt <= slice_cnt_nxt;
      group_cnt <= group_cnt_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    slice_cnt_nxt = slice_cnt;
    group_cnt_nxt = group_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          row_cnt_nxt   = '0;
          slice_cnt_nxt = '0;
          group_cnt_nxt = '0;
          state_nxt     = FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          if (row_cnt == ROW_LAST) begin
            row_cnt_nxt = '0;
            state_nxt   = DRAIN;
          end else begin
            row_cnt_nxt = row_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (slice_cnt == SLICE_LAST) begin
            slice_cnt_nxt = '0;
            if (group_cnt == GROUP_LAST) begin
              state_nxt = FIN;
            end else begin
              group_cnt_nxt = group_cnt + 1'b1;
              state_nxt     = FILL;
            end
          end else begin
            slice_cnt_nxt = slice_cnt + 1'b1;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decodes of registered state, so they drop with the async reset
  always_comb begin
    in_ready     = (state == FILL);
    out_valid    = (state == DRAIN);
    busy         = (state != IDLE);
    done         = (state == FIN);
    buf_wr_en    = in_valid && in_ready;
    buf_wr_row   = row_cnt;
    buf_rd_slice = slice_cnt;
    group_idx    = group_cnt;
  end

`ifdef N2R_STALL_CNT_EN
  // Back-pressure counter: DRAIN cycles where the multiplier refuses the slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == DRAIN && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
